// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_mc_pkg;

    // Controller states; S_SPARE is never entered and recovers to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_IMMEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JEX     = 4'd12,
        S_JALEX   = 4'd13,
        S_SPARE   = 4'd14
    } state_t;

    // How the ALU decoder should interpret the current state.
    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_ADD   = 3'd1,
        CLS_SUB   = 3'd2,
        CLS_RTYPE = 3'd3,
        CLS_IMM   = 3'd4
    } alu_cls_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type functs (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Datapath mux select encodings
    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_DATA   = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;
    localparam logic [1:0] RD_RT     = 2'b00;
    localparam logic [1:0] RD_RD     = 2'b01;
    localparam logic [1:0] RD_RA     = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States whose exit to FETCH completes an instruction.
    function automatic logic is_retire_state(input state_t s);
        case (s)
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_BNEEX,
            S_IMMWB, S_JEX, S_JALEX: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU decoder: maps the state class plus op/funct to the ALU operation,
// immediate extension mode and an unsupported-funct flag.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       immext,
    output logic       funct_illegal
);

    // Per-class operation select; idle classes fall to AND (all zero).
    always_comb begin
        alucontrol    = ALU_AND;
        immext        = 1'b0;
        funct_illegal = 1'b0;
        case (cls)
            CLS_ADD: alucontrol = ALU_ADD;
            CLS_SUB: alucontrol = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            CLS_IMM: begin
                case (op)
                    OP_SLTI: alucontrol = ALU_SLT;
                    OP_ANDI: begin alucontrol = ALU_AND; immext = 1'b1; end
                    OP_ORI:  begin alucontrol = ALU_OR;  immext = 1'b1; end
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with memory wait states and a retired
// instruction counter. Outputs are a Moore decode of the state, qualified
// only by ready (FETCH) and zero (branches).
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcen,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             alusrca,
    output logic             iord,
    output logic [1:0]       memtoreg,
    output logic [1:0]       regdst,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic             immext,
    output logic [2:0]       alucontrol,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    state_t   state, state_nxt;
    alu_cls_t cls;
    logic     ready;
    logic     pcwrite, branch, branchne;
    logic     op_illegal, funct_illegal;
    logic     retire;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // ALU class depends on state only, kept apart so the decoder's
    // funct_illegal can feed next-state without a combinational loop.
    always_comb begin
        cls = CLS_NONE;
        case (state)
            S_FETCH, S_DECODE, S_MEMADR: cls = CLS_ADD;
            S_BEQEX, S_BNEEX:            cls = CLS_SUB;
            S_RTYPEEX:                   cls = CLS_RTYPE;
            S_IMMEX, S_IMMWB:            cls = CLS_IMM;
            default:                     cls = CLS_NONE;
        endcase
    end

    mips_mc_aludec u_aludec (
        .cls           (cls),
        .op            (op),
        .funct         (funct),
        .alucontrol    (alucontrol),
        .immext        (immext),
        .funct_illegal (funct_illegal)
    );

    // Next-state and Moore output decode.
    always_comb begin
        state_nxt  = state;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = WD_ALUOUT;
        regdst     = RD_RT;
        alusrcb    = SRCB_B;
        pcsrc      = PC_ALURES;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        op_illegal = 1'b0;
        case (state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = ready;
                pcwrite = ready;
                if (ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW:                      state_nxt = S_MEMADR;
                    OP_RTYPE:                          state_nxt = S_RTYPEEX;
                    OP_BEQ:                            state_nxt = S_BEQEX;
                    OP_BNE:                            state_nxt = S_BNEEX;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_nxt = S_IMMEX;
                    OP_J:                              state_nxt = S_JEX;
                    OP_JAL:                            state_nxt = S_JALEX;
                    default: begin
                        op_illegal = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_IMM;
                state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite  = 1'b1;
                memtoreg  = WD_DATA;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (ready) state_nxt = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca   = 1'b1;
                state_nxt = funct_illegal ? S_FETCH : S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite  = 1'b1;
                regdst    = RD_RD;
                state_nxt = S_FETCH;
            end
            S_BEQEX: begin
                alusrca   = 1'b1;
                pcsrc     = PC_ALUOUT;
                branch    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BNEEX: begin
                alusrca   = 1'b1;
                pcsrc     = PC_ALUOUT;
                branchne  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_IMMEX: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_IMM;
                state_nxt = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JEX: begin
                pcsrc     = PC_JUMP;
                pcwrite   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JALEX: begin
                pcsrc     = PC_JUMP;
                pcwrite   = 1'b1;
                regwrite  = 1'b1;
                regdst    = RD_RA;
                memtoreg  = WD_PC;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // funct_illegal is only ever raised in RTYPEEX (the only CLS_RTYPE state).
    assign illegal = op_illegal | funct_illegal;
    assign pcen    = pcwrite | (branch & zero) | (branchne & ~zero);
    assign retire  = (state_nxt == S_FETCH) && is_retire_state(state);

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: a vector table of single instructions
// (outputs in the third cycle, cycle count, writeback, instret step) plus
// hand sequences for stalls, illegal pulses, IMMWB and mid-stall reset.
module tb_mips_mc_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        pcen, memread, memwrite, irwrite, regwrite, alusrca, iord;
    logic [1:0]  memtoreg, regdst, alusrcb, pcsrc;
    logic        immext, illegal;
    logic [2:0]  alucontrol;
    logic [31:0] instret;

    mips_mc_control #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .immext(immext),
        .alucontrol(alucontrol), .instret(instret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcen, memread, memwrite, irwrite, regwrite, alusrca, iord;
        logic [1:0] memtoreg, regdst, alusrcb, pcsrc;
        logic       immext;
        logic [2:0] aluc;
        logic       ill;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op, funct;
        logic       zero;
        outs_t      exp;
        int         cycles;
        int         inc;
        logic       rw;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_instret = 0;

    function automatic outs_t mk(logic pe, logic mr, logic mw, logic ir, logic rw,
                                 logic sa, logic io, logic [1:0] mt, logic [1:0] rd,
                                 logic [1:0] sb, logic [1:0] ps, logic ie,
                                 logic [2:0] ac, logic il);
        outs_t o;
        o = '{pe, mr, mw, ir, rw, sa, io, mt, rd, sb, ps, ie, ac, il};
        return o;
    endfunction

    function automatic outs_t cur();
        outs_t o;
        o = '{pcen, memread, memwrite, irwrite, regwrite, alusrca, iord,
              memtoreg, regdst, alusrcb, pcsrc, immext, alucontrol, illegal};
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input outs_t e, input int cyc, input int inc,
                       input logic rw);
        vec_t v;
        v.name = n; v.op = o; v.funct = f; v.zero = z; v.exp = e;
        v.cycles = cyc; v.inc = inc; v.rw = rw;
        vq.push_back(v);
    endtask

    // Runs one instruction from a FETCH cycle (mem_ready=1) back to FETCH.
    task automatic run_vec(input vec_t v);
        int    cyc;
        logic  rw_seen;
        outs_t cap;
        op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
        #1;
        cyc = 1; rw_seen = regwrite; cap = '0;
        while (cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            rw_seen = rw_seen | regwrite;
            if (cyc == 3) cap = cur();
            if (irwrite) break;
        end
        exp_instret += v.inc;
        chk({v.name, " cyc3 outputs"}, 32'(cap), 32'(v.exp));
        chk({v.name, " cycles"}, 32'(cyc - 1), 32'(v.cycles));
        chk({v.name, " regwrite seen"}, 32'(rw_seen), 32'(v.rw));
        chk({v.name, " instret"}, instret, 32'(exp_instret));
    endtask

    initial begin
        outs_t memadr, fetch_o;
        logic [0:9] sched;
        int   ir_pulses, ir_cyc;

        memadr  = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b10,2'b00,0,3'b010,0);
        fetch_o = mk(1,1,0,1,0,0,0,2'b00,2'b00,2'b01,2'b00,0,3'b010,0);
        add("lw",    6'b100011, 6'b0, 0, memadr, 5, 1, 1);
        add("sw",    6'b101011, 6'b0, 0, memadr, 4, 1, 0);
        add("add",   6'b000000, 6'b100000, 0, mk(0,0,0,0,0,1,0,0,0,2'b00,0,0,3'b010,0), 4, 1, 1);
        add("sub",   6'b000000, 6'b100010, 0, mk(0,0,0,0,0,1,0,0,0,2'b00,0,0,3'b110,0), 4, 1, 1);
        add("and",   6'b000000, 6'b100100, 0, mk(0,0,0,0,0,1,0,0,0,2'b00,0,0,3'b000,0), 4, 1, 1);
        add("or",    6'b000000, 6'b100101, 0, mk(0,0,0,0,0,1,0,0,0,2'b00,0,0,3'b001,0), 4, 1, 1);
        add("slt",   6'b000000, 6'b101010, 0, mk(0,0,0,0,0,1,0,0,0,2'b00,0,0,3'b111,0), 4, 1, 1);
        add("rill",  6'b000000, 6'b000111, 0, mk(0,0,0,0,0,1,0,0,0,2'b00,0,0,3'b000,1), 3, 0, 0);
        add("beq z1",6'b000100, 6'b0, 1, mk(1,0,0,0,0,1,0,0,0,2'b00,2'b01,0,3'b110,0), 3, 1, 0);
        add("beq z0",6'b000100, 6'b0, 0, mk(0,0,0,0,0,1,0,0,0,2'b00,2'b01,0,3'b110,0), 3, 1, 0);
        add("bne z1",6'b000101, 6'b0, 1, mk(0,0,0,0,0,1,0,0,0,2'b00,2'b01,0,3'b110,0), 3, 1, 0);
        add("bne z0",6'b000101, 6'b0, 0, mk(1,0,0,0,0,1,0,0,0,2'b00,2'b01,0,3'b110,0), 3, 1, 0);
        add("addi",  6'b001000, 6'b0, 0, mk(0,0,0,0,0,1,0,0,0,2'b10,0,0,3'b010,0), 4, 1, 1);
        add("slti",  6'b001010, 6'b0, 0, mk(0,0,0,0,0,1,0,0,0,2'b10,0,0,3'b111,0), 4, 1, 1);
        add("andi",  6'b001100, 6'b0, 0, mk(0,0,0,0,0,1,0,0,0,2'b10,0,1,3'b000,0), 4, 1, 1);
        add("ori",   6'b001101, 6'b0, 0, mk(0,0,0,0,0,1,0,0,0,2'b10,0,1,3'b001,0), 4, 1, 1);
        add("j",     6'b000010, 6'b0, 0, mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,0,3'b000,0), 3, 1, 0);
        add("jal",   6'b000011, 6'b0, 0, mk(1,0,0,0,1,0,0,2'b10,2'b10,2'b00,2'b10,0,3'b000,0), 3, 1, 1);
        add("opill", 6'b111111, 6'b0, 0, fetch_o, 2, 0, 0);

        // Reset state
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        #2;
        chk("reset outputs", 32'(cur()), 32'(fetch_o));
        chk("reset instret", instret, 32'd0);
        #10 reset = 1'b0;   // released at t=12, between edges

        foreach (vq[i]) run_vec(vq[i]);

        // Illegal op: one-cycle pulse in DECODE only
        op = 6'b111111; #1;
        chk("opill pre", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        chk("opill decode pulse", 32'(illegal), 32'd1);
        @(posedge clk); #1;
        chk("opill back fetch", {30'd0, illegal, irwrite}, 32'b01);
        chk("opill instret", instret, 32'(exp_instret));

        // ori writeback holds immext/alucontrol
        op = 6'b001101;
        repeat (3) @(posedge clk);
        #1;
        chk("ori immwb", {22'd0, regwrite, regdst, memtoreg, immext, alucontrol},
            {22'd0, 1'b1, 2'b00, 2'b00, 1'b1, 3'b001});
        @(posedge clk); #1;
        exp_instret++;
        chk("ori instret", instret, 32'(exp_instret));

        // lw with 3 FETCH stall cycles and 2 MEMRD stall cycles
        op = 6'b100011;
        sched = 10'b0001110011;
        ir_pulses = 0; ir_cyc = 0;
        for (int c = 0; c < 10; c++) begin
            mem_ready = sched[c]; #1;
            if (irwrite) begin ir_pulses++; ir_cyc = c + 1; end
            if (c < 3) chk("lw stall pcen", 32'(pcen), 32'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1; #1;
        chk("lw irwrite pulses", 32'(ir_pulses), 32'd1);
        chk("lw irwrite cycle", 32'(ir_cyc), 32'd4);
        chk("lw back fetch after 10", {30'd0, irwrite, iord}, 32'b10);
        exp_instret++;
        chk("lw stall instret", instret, 32'(exp_instret));

        // Reset in a MEMWR stall
        op = 6'b101011;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0; #1;
        chk("memwr stalled memwrite", 32'(memwrite), 32'd1);
        @(posedge clk); #1;
        chk("memwr held", 32'(memwrite), 32'd1);
        #1 reset = 1'b1; #1;
        chk("reset drops memwrite", 32'(memwrite), 32'd0);
        chk("reset clears instret", instret, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        chk("post reset fetch", {29'd0, memread, iord, memwrite}, 32'b100);
        chk("post reset instret", instret, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Parametrised multicycle MIPS control unit, next generation of the existing multicycle controller.
- Adds a memory wait-state handshake (mem_ready) and a retired-instruction counter.
- Adds BNE, SLTI, ANDI, ORI and JAL; unsupported opcodes/functs are flagged.
- Sits beside the multicycle datapath and drives all its mux selects and enables.

Parameters:
MEM_WAIT_EN, 1, 1: memory accesses stall until mem_ready; 0: mem_ready ignored and treated as 1.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
op  in  6  instr[31:26]
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access this cycle
pcen  out  1  PC register enable
memread  out  1  memory read request
memwrite  out  1  memory write request
irwrite  out  1  instruction register enable
regwrite  out  1  register file write enable
alusrca  out  1  0 = PC, 1 = A
iord  out  1  0 = PC address, 1 = ALUOut address
memtoreg  out  2  WD3 select: 00 = ALUOut, 01 = Data, 10 = PC
regdst  out  2  write register select: 00 = rt, 01 = rd, 10 = 31
alusrcb  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm << 2
pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
immext  out  1  1 = zero-extend imm, 0 = sign-extend imm
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
instret  out  CNT_W  count of retired instructions
illegal  out  1  one-cycle pulse on an unsupported op or funct

Behaviour:
- Reset (async, any state) -> state FETCH, instret = 0. All outputs are then the FETCH decode below. Unlisted outputs are 0 in every state.
- Outputs are a Moore decode of state, except the mem_ready and zero qualifications below.
- pcen = pcwrite | (branch & zero) | (branchne & ~zero).
- "ready" = mem_ready when MEM_WAIT_EN = 1, otherwise 1.

States and outputs:
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00, irwrite=ready, pcwrite=ready. -> DECODE if ready, else stay.
- DECODE: alusrca=0, alusrcb=11, add.
  - op 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 000101 -> BNEEX.
  - op 001000/001010/001100/001101 -> IMMEX; 000010 -> JEX; 000011 -> JALEX.
  - any other op: illegal=1, -> FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. -> MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. -> MEMWB if ready, else stay.
- MEMWB: regwrite=1, regdst=00, memtoreg=01. -> FETCH.
- MEMWR: memwrite=1, iord=1; memwrite is held for every stall cycle. -> FETCH if ready, else stay.
- RTYPEEX: alusrca=1, alusrcb=00. funct mapping:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - other funct: illegal=1, -> FETCH with no writeback; otherwise -> RTYPEWB.
- RTYPEWB: regwrite=1, regdst=01, memtoreg=00. -> FETCH.
- BEQEX / BNEEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch (BEQ) or branchne (BNE). -> FETCH.
- IMMEX: alusrca=1, alusrcb=10. addi: add; slti: slt; andi: and with immext=1; ori: or with immext=1. -> IMMWB.
- IMMWB: regwrite=1, regdst=00, memtoreg=00; immext and alucontrol are held from IMMEX. -> FETCH.
- JEX: pcsrc=10, pcwrite=1. -> FETCH.
- JALEX: pcsrc=10, pcwrite=1, regwrite=1, regdst=10, memtoreg=10. The PC already holds PC+4, so $31 receives the return address. -> FETCH.

instret:
- Increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWR (ready), RTYPEWB, BEQEX, BNEEX, IMMWB, JEX or JALEX.
- Illegal exits do not count.

Stalls and reset:
- While stalled, every output is held stable, and irwrite/pcwrite stay 0 until the ready cycle.
- Reset mid-stall abandons the access; memwrite drops asynchronously.

Decomposition:
- Package mips_mc_pkg: state enum (15 states), opcode and funct localparams, alucontrol codes, mux-select encodings.
- One sub-module, mips_mc_aludec: combinational mapping of (state class, op, funct) to {alucontrol, immext, funct_illegal}.

Test Plan:
- Reset asserted mid-MEMWR with memwrite=1 -> memwrite=0 immediately; next clk in FETCH; instret=0.
- lw with MEM_WAIT_EN=1 and mem_ready low for 3 cycles in FETCH and 2 in MEMRD:
  - irwrite pulses once, only on the ready cycle.
  - The instruction takes 5 + 5 stall = 10 cycles.
  - instret goes 0 -> 1.
- beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX. bne with zero=1 -> pcen=0. bne with zero=0 -> pcen=1.
- ori (op 001101) -> IMMEX: alucontrol=001, immext=1, alusrcb=10. IMMWB: regwrite=1, regdst=00, memtoreg=00.
- jal (op 000011) -> JALEX in 3 cycles, with pcwrite=1, regwrite=1, regdst=10, memtoreg=10, pcsrc=10.
- op 111111 -> illegal=1 for one cycle in DECODE, back to FETCH, instret unchanged. Repeat with R-type funct 000111 -> illegal pulse in RTYPEEX and no regwrite.
